// File: rtl/uv_wb_arb.sv
// uv_wb_arb: write-back arbiter and register scoreboard.
//
// The execution units share the register file's single write port. This block
// grants them round-robin and drives that port from a register. It also keeps
// one busy bit per architectural register, set when a producer issues and
// cleared when its result is written. The issue stage reads these bits to
// stall on RAW hazards.
//
// Ports:
//   clk, rst              core clock; synchronous active-high reset
//   wb_req/wb_idx/wb_data per-requester write-back request, index and data
//                         (requester i uses slice i of the packed buses)
//   wb_gnt                one-hot combinational grant, same cycle as request
//   rf_wr_vld/idx/data    registered register-file write port
//   iss_vld/iss_idx       issue of a register-writing instruction
//   sb_flush              clear the whole scoreboard
//   ra/rb/rc_idx          source indices to check
//   ra/rb/rc_busy         source has a pending producer
//   sb_any                some register has a pending producer
//
// Handshake: a requester holds wb_req, wb_idx and wb_data stable until it
// sees its wb_gnt bit; wb_gnt high for one cycle completes the transfer, and
// the requester may drop or replace its request on the following cycle.
module uv_wb_arb #(
  parameter int RF_AW = 5,
  parameter int RF_DP = 2**RF_AW,
  parameter int RF_DW = 32,
  parameter int WB_N  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_N-1:0]        wb_req,
  input  logic [WB_N*RF_AW-1:0]  wb_idx,
  input  logic [WB_N*RF_DW-1:0]  wb_data,
  output logic [WB_N-1:0]        wb_gnt,
  output logic                   rf_wr_vld,
  output logic [RF_AW-1:0]       rf_wr_idx,
  output logic [RF_DW-1:0]       rf_wr_data,
  input  logic                   iss_vld,
  input  logic [RF_AW-1:0]       iss_idx,
  input  logic                   sb_flush,
  input  logic [RF_AW-1:0]       ra_idx,
  input  logic [RF_AW-1:0]       rb_idx,
  input  logic [RF_AW-1:0]       rc_idx,
  output logic                   ra_busy,
  output logic                   rb_busy,
  output logic                   rc_busy,
  output logic                   sb_any
);

  localparam int PTR_W = (WB_N > 1) ? $clog2(WB_N) : 1;

  // Round-robin pointer: the requester searched first this cycle.
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] win;
  logic             found;
  logic [RF_AW-1:0] win_idx;
  logic [RF_DW-1:0] win_data;

  logic [RF_DP-1:0] busy;
  logic [RF_DP-1:0] busy_nxt;

  // Search ptr, ptr+1, ... with wrap; the first requester found wins.
  always_comb begin
    wb_gnt   = '0;
    win      = '0;
    cand     = '0;
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int k = 0; k < WB_N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % WB_N);
      if (!found && wb_req[cand]) begin
        found        = 1'b1;
        win          = cand;
        wb_gnt[cand] = 1'b1;
      end
    end
    for (int i = 0; i < WB_N; i++) begin
      if (wb_gnt[i]) begin
        win_idx  = wb_idx[i*RF_AW +: RF_AW];
        win_data = wb_data[i*RF_DW +: RF_DW];
      end
    end
  end

  // Pointer and write-port register. A winner targeting x0 is consumed like
  // any other, but its write enable is suppressed so x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      rf_wr_vld  <= 1'b0;
      rf_wr_idx  <= '0;
      rf_wr_data <= '0;
    end else if (found) begin
      ptr        <= (win == PTR_W'(WB_N - 1)) ? '0 : win + 1'b1;
      rf_wr_vld  <= (win_idx != '0);
      rf_wr_idx  <= win_idx;
      rf_wr_data <= win_data;
    end else begin
      rf_wr_vld  <= 1'b0;
    end
  end

  // Scoreboard update. The clear uses the registered write port, so busy drops
  // on the same edge the register file takes the data. A set applied after the
  // clear lets a newer producer win over a retiring one; flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr_vld) begin
      busy_nxt[rf_wr_idx] = 1'b0;
    end
    if (iss_vld && (iss_idx != '0)) begin
      busy_nxt[iss_idx] = 1'b1;
    end
    if (sb_flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign ra_busy = busy[ra_idx];
  assign rb_busy = busy[rb_idx];
  assign rc_busy = busy[rc_idx];
  assign sb_any  = |busy;

endmodule

// File: tb/tb_uv_wb_arb.sv
// Testbench for uv_wb_arb: directed steps followed by a randomized phase,
// checked against a behavioural model of the arbitration and scoreboard rules.
module tb_uv_wb_arb;

  localparam int AW = 5;
  localparam int DP = 32;
  localparam int DW = 32;
  localparam int N  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      wb_req;
  logic [N*AW-1:0]   wb_idx;
  logic [N*DW-1:0]   wb_data;
  logic [N-1:0]      wb_gnt;
  logic              rf_wr_vld;
  logic [AW-1:0]     rf_wr_idx;
  logic [DW-1:0]     rf_wr_data;
  logic              iss_vld;
  logic [AW-1:0]     iss_idx;
  logic              sb_flush;
  logic [AW-1:0]     ra_idx, rb_idx, rc_idx;
  logic              ra_busy, rb_busy, rc_busy;
  logic              sb_any;

  uv_wb_arb #(.RF_AW(AW), .RF_DP(DP), .RF_DW(DW), .WB_N(N)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .rf_wr_vld(rf_wr_vld), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .iss_vld(iss_vld), .iss_idx(iss_idx), .sb_flush(sb_flush),
    .ra_idx(ra_idx), .rb_idx(rb_idx), .rc_idx(rc_idx),
    .ra_busy(ra_busy), .rb_busy(rb_busy), .rc_busy(rc_busy),
    .sb_any(sb_any)
  );

  // ---------------- reference model ----------------
  int          tests = 0;
  int          fails = 0;
  int          m_ptr = 0;
  bit          m_busy [DP];
  logic        m_vld   = 1'b0;
  logic [AW-1:0] m_widx  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [N-1:0]  m_gnt;
  int          m_win;
  int          wait_cnt [N];
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_grant();
    m_gnt = '0;
    m_win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_win < 0 && wb_req[j]) begin
        m_win = j;
        m_gnt[j] = 1'b1;
      end
    end
  endfunction

  function automatic bit model_any();
    bit a;
    a = 1'b0;
    for (int i = 0; i < DP; i++) a |= m_busy[i];
    return a;
  endfunction

  // One clock cycle: check combinational outputs, advance the model at the
  // edge, then check the registered write port.
  task automatic cycle();
    logic [AW-1:0] idx;
    logic [DW-1:0] dat;
    logic [AW+DW-1:0] e;
    #1;
    model_grant();
    chk("wb_gnt", 64'(wb_gnt), 64'(m_gnt));
    chk("ra_busy", 64'(ra_busy), 64'(m_busy[ra_idx]));
    chk("rb_busy", 64'(rb_busy), 64'(m_busy[rb_idx]));
    chk("rc_busy", 64'(rc_busy), 64'(m_busy[rc_idx]));
    chk("sb_any", 64'(sb_any), 64'(model_any()));
    for (int i = 0; i < N; i++) begin
      if (wb_req[i]) chk("starvation", 64'(wait_cnt[i] < N), 64'(1));
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_vld = 1'b0; m_widx = '0; m_wdata = '0;
      for (int i = 0; i < DP; i++) m_busy[i] = 1'b0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      exp_q.delete();
    end else begin
      if (m_vld) m_busy[m_widx] = 1'b0;
      if (iss_vld && iss_idx != 0) m_busy[iss_idx] = 1'b1;
      if (sb_flush) for (int i = 0; i < DP; i++) m_busy[i] = 1'b0;
      if (m_win >= 0) begin
        idx = wb_idx[m_win*AW +: AW];
        dat = wb_data[m_win*DW +: DW];
        m_vld = (idx != 0);
        m_widx = idx;
        m_wdata = dat;
        m_ptr = (m_win + 1) % N;
        if (idx != 0) exp_q.push_back({idx, dat});
      end else begin
        m_vld = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (wb_req[i] && !m_gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
      end
    end
    #1;
    chk("rf_wr_vld", 64'(rf_wr_vld), 64'(m_vld));
    chk("rf_wr_idx", 64'(rf_wr_idx), 64'(m_widx));
    chk("rf_wr_data", 64'(rf_wr_data), 64'(m_wdata));
    if (rf_wr_vld === 1'b1) begin
      chk("wr_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_pair", 64'({rf_wr_idx, rf_wr_data}), 64'(e));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [AW-1:0] idx, input logic [DW-1:0] d);
    wb_req[i] = 1'b1;
    wb_idx[i*AW +: AW] = idx;
    wb_data[i*DW +: DW] = d;
  endtask

  task automatic issue(input logic [AW-1:0] idx);
    iss_vld = 1'b1;
    iss_idx = idx;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DP; i++) m_busy[i] = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rst = 1'b1; wb_req = '0; wb_idx = '0; wb_data = '0;
    iss_vld = 1'b0; iss_idx = '0; sb_flush = 1'b0;
    ra_idx = '0; rb_idx = '0; rc_idx = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then idle.
    rst = 1'b0; ra_idx = 5;
    cycle(); cycle();

    // Single LSU request.
    set_req(1, 7, 32'hDEADBEEF);
    cycle();
    wb_req = '0;
    cycle(); cycle();

    // All three requesters held from reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_req(0, 1, 32'h1111_0001);
    set_req(1, 2, 32'h2222_0002);
    set_req(2, 3, 32'h3333_0003);
    repeat (4) cycle();
    wb_req = '0;
    cycle();

    // Issue x3, ALU writes it four cycles later.
    ra_idx = 3;
    issue(3);
    cycle();
    iss_vld = 1'b0;
    repeat (3) cycle();
    set_req(0, 3, 32'hCAFE_0003);
    cycle();
    wb_req = '0;
    repeat (2) cycle();

    // New producer of x4 issues in the cycle x4 is written back.
    rb_idx = 4;
    issue(4);
    cycle();
    iss_vld = 1'b0;
    set_req(0, 4, 32'h4444_4444);
    cycle();
    wb_req = '0;
    issue(4);
    cycle();
    iss_vld = 1'b0;
    repeat (2) cycle();

    // Write-back to x0 is consumed but not written.
    set_req(2, 0, 32'h0BAD_0BAD);
    cycle();
    wb_req = '0;
    cycle();

    // Flush wins over a same-cycle issue.
    rc_idx = 9;
    issue(1); cycle();
    issue(2); cycle();
    issue(9); cycle();
    sb_flush = 1'b1; issue(10); rb_idx = 10;
    cycle();
    sb_flush = 1'b0; iss_vld = 1'b0;
    cycle();

    // Randomized phase: requesters hold until granted.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) wb_req[i] = 1'b0;
        if (!wb_req[i] && $urandom_range(0, 99) < 60) begin
          set_req(i, AW'($urandom_range(0, DP - 1)), $urandom);
        end
      end
      iss_vld  = ($urandom_range(0, 99) < 40);
      iss_idx  = AW'($urandom_range(0, DP - 1));
      sb_flush = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 99) < 2);
      ra_idx   = AW'($urandom_range(0, DP - 1));
      rb_idx   = AW'($urandom_range(0, 7));
      rc_idx   = m_widx;
      cycle();
    end

    // Drain.
    rst = 1'b0; wb_req = '0; iss_vld = 1'b0; sb_flush = 1'b0;
    repeat (3) cycle();
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
